// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : cpu_fetch
// Description : Instruction fetch stage of the LEGv8 single-cycle CPU. Owns
//               the program counter, reads instruction memory over a
//               req/ack handshake, hands each instruction to decode under a
//               valid/ready handshake, applies branch redirects from execute
//               and stops fetching once a HALT instruction is accepted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W     - PC / instruction address width
//   RESET_PC   - PC loaded on reset (bits [1:0] must be 0)
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   imem_req   out  instruction memory read request
//   imem_addr  out  read address, held stable until imem_ack
//   imem_ack   in   read data valid (may coincide with imem_req)
//   imem_rdata in   instruction word, sampled only with imem_ack
//   inst       out  instruction presented to decode
//   inst_pc    out  address of inst
//   inst_valid out  inst / inst_pc valid
//   inst_ready in   decode accepts inst this cycle
//   br_taken   in   single-cycle redirect pulse from execute
//   br_target  in   redirect address (bits [1:0] forced to 00)
//   halted     out  HALT accepted, fetch stopped
// ============================================================================
module cpu_fetch #(
    parameter int          ADDR_W   = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_RESET_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [10:0]       C_HALT_OP  = 11'h7FF;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_pc,        w_pc_nxt;
    logic              r_squash,    w_squash_nxt;
    logic              r_halt_pend, w_halt_pend_nxt;
    logic              r_req,       w_req_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [31:0]       r_inst,      w_inst_nxt;
    logic [ADDR_W-1:0] r_inst_pc,   w_inst_pc_nxt;
    logic              r_valid,     w_valid_nxt;
    logic              r_halted,    w_halted_nxt;

    logic [ADDR_W-1:0] w_br_tgt;

    // Redirect targets are always word aligned.
    assign w_br_tgt = br_target & ~(ADDR_W'(3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= C_RESET_PC;
            r_squash    <= 1'b0;
            r_halt_pend <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= C_RESET_PC;
            r_inst      <= 32'h0;
            r_inst_pc   <= '0;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_squash    <= w_squash_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_inst      <= w_inst_nxt;
            r_inst_pc   <= w_inst_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_squash_nxt    = r_squash;
        w_halt_pend_nxt = r_halt_pend;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_inst_nxt      = r_inst;
        w_inst_pc_nxt   = r_inst_pc;
        w_valid_nxt     = r_valid;
        w_halted_nxt    = r_halted;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_pc;
            end

            S_FETCH: begin
                if (imem_ack) begin
                    if (r_squash || br_taken) begin
                        // Data belongs to the wrong path: drop it and
                        // immediately re-request at the (new) PC.
                        w_squash_nxt = 1'b0;
                        w_req_nxt    = 1'b1;
                        if (br_taken) begin
                            w_pc_nxt   = w_br_tgt;
                            w_addr_nxt = w_br_tgt;
                        end else begin
                            w_addr_nxt = r_pc;
                        end
                    end else begin
                        w_inst_nxt      = imem_rdata;
                        w_inst_pc_nxt   = r_pc;
                        w_valid_nxt     = 1'b1;
                        w_pc_nxt        = r_pc + ADDR_W'(4);
                        w_halt_pend_nxt = (imem_rdata[31:21] == C_HALT_OP);
                        w_req_nxt       = 1'b0;
                        w_state_nxt     = S_HOLD;
                    end
                end else if (br_taken) begin
                    // Request in flight cannot be cancelled; r_addr keeps
                    // the old address while r_pc parks the target.
                    w_squash_nxt = 1'b1;
                    w_pc_nxt     = w_br_tgt;
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    // Flush wins over a simultaneous decode accept.
                    w_valid_nxt     = 1'b0;
                    w_halt_pend_nxt = 1'b0;
                    w_pc_nxt        = w_br_tgt;
                    w_addr_nxt      = w_br_tgt;
                    w_req_nxt       = 1'b1;
                    w_state_nxt     = S_FETCH;
                end else if (inst_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_halt_pend) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALT;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                // Terminal: only reset leaves this state.
                w_req_nxt    = 1'b0;
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_valid;
    assign halted     = r_halted;

endmodule
`default_nettype wire
